// File: rtl/mul_ack_unit.sv
// mul_ack_unit: registered WIDTH x WIDTH multiplier with a one-cycle
// completion acknowledge. Operands are sampled on any rising clk with en=1;
// the full 2*WIDTH product and ack appear one clock later.
//
// Handshake: en is a valid-only strobe (there is no ready; every enabled cycle
// is accepted). ack is a level that mirrors the previous cycle's en. The
// consumer must take out in the same cycle ack=1, because nothing holds the
// acknowledge until it is consumed.
module mul_ack_unit #(
    parameter int WIDTH       = 8,
    parameter bit SIGNED_MODE = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,   // asynchronous, active-low
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 en,
    output logic [2*WIDTH-1:0]   out,
    output logic                 ack
);

    logic [2*WIDTH-1:0] prod_d;
    logic [2*WIDTH-1:0] out_q;
    logic [2*WIDTH-1:0] out_d;
    logic               ack_q;
    logic               ack_d;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;

    // Widen both operands to 2*WIDTH (sign- or zero-extended) so the product
    // is exact: the low 2*WIDTH bits of the widened product are the true result.
    always_comb begin
        a_ext = {{WIDTH{1'b0}}, a};
        b_ext = {{WIDTH{1'b0}}, b};
        if (SIGNED_MODE) begin
            a_ext = {{WIDTH{a[WIDTH-1]}}, a};
            b_ext = {{WIDTH{b[WIDTH-1]}}, b};
        end
        prod_d = a_ext * b_ext;
    end

    // Next-state: capture a new product when enabled, otherwise hold out;
    // ack simply follows en.
    always_comb begin
        out_d = out_q;
        ack_d = en;
        if (en) begin
            out_d = prod_d;
        end
    end

    // Output registers; reset clears both immediately and discards any request
    // that was sampled but not yet acknowledged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
            ack_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ack_q <= ack_d;
        end
    end

    assign out = out_q;
    assign ack = ack_q;

endmodule

// File: tb/tb_mul_ack_unit.sv
// Bench for mul_ack_unit: one unsigned and one signed 8-bit instance share the
// same stimulus; a behavioural model computes expected products with plain
// integer arithmetic.
module tb_mul_ack_unit;

    localparam int W = 8;

    logic            clk;
    logic            reset;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            en;
    logic [2*W-1:0]  out_u;
    logic            ack_u;
    logic [2*W-1:0]  out_s;
    logic            ack_s;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [2*W-1:0]  m_out_u;
    logic [2*W-1:0]  m_out_s;
    logic            m_ack;
    logic [2*W-1:0]  exp_q[$];

    mul_ack_unit #(.WIDTH(W), .SIGNED_MODE(1'b0)) u_dut_u (
        .clk(clk), .reset(reset), .a(a), .b(b), .en(en), .out(out_u), .ack(ack_u)
    );

    mul_ack_unit #(.WIDTH(W), .SIGNED_MODE(1'b1)) u_dut_s (
        .clk(clk), .reset(reset), .a(a), .b(b), .en(en), .out(out_s), .ack(ack_s)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input logic [W-1:0] v);
        int r;
        r = int'(v);
        if (r >= 128) r = r - 256;
        return r;
    endfunction

    // Compare both instances against the model.
    task automatic check_all(input string tag);
        check({tag, ".out_u"}, 32'(out_u), 32'(m_out_u));
        check({tag, ".ack_u"}, 32'(ack_u), 32'(m_ack));
        check({tag, ".out_s"}, 32'(out_s), 32'(m_out_s));
        check({tag, ".ack_s"}, 32'(ack_s), 32'(m_ack));
    endtask

    // Drive one cycle's inputs (called #1 after a rising edge), advance the
    // model at the next edge and check shortly after it.
    task automatic step(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic eni,
                        input string tag);
        int pu;
        int ps;
        a  = ai;
        b  = bi;
        en = eni;
        @(posedge clk);
        if (reset) begin
            m_ack = eni;
            if (eni) begin
                pu = int'(ai) * int'(bi);
                ps = to_signed(ai) * to_signed(bi);
                m_out_u = 16'(pu);
                m_out_s = 16'(ps);
                exp_q.push_back(16'(pu));
            end
        end
        #1;
        check_all(tag);
        if (m_ack && exp_q.size() > 0) begin
            check({tag, ".sb"}, 32'(out_u), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic model_reset();
        m_out_u = '0;
        m_out_s = '0;
        m_ack   = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        // reset
        reset = 1'b0;
        a = '0;
        b = '0;
        en = 1'b0;
        model_reset();
        #2;
        check_all("reset_async");
        @(posedge clk);
        #1;
        check_all("reset_hold");
        reset = 1'b1;

        // single request, then idle
        step(8'd4, 8'd10, 1'b1, "single");
        step(8'd4, 8'd10, 1'b0, "single_idle");

        // back-to-back streams
        for (int i = 0; i < 3; i++) step(8'd6, 8'd12, 1'b1, "stream72");
        for (int i = 0; i < 3; i++) step(8'd8, 8'd16, 1'b1, "stream128");

        // unsigned extremes
        step(8'd255, 8'd255, 1'b1, "max");
        step(8'd0, 8'd200, 1'b1, "zero");

        // signed patterns
        step(8'hFD, 8'd7, 1'b1, "neg3x7");
        step(8'h80, 8'h80, 1'b1, "min_x_min");
        step(8'hFF, 8'd5, 1'b1, "neg1x5");

        // operands toggling while disabled
        for (int i = 0; i < 10; i++)
            step(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0, "idle_toggle");

        // reset mid-operation: out=40 with another request in flight
        step(8'd4, 8'd10, 1'b1, "pre_reset");
        a  = 8'd9;
        b  = 8'd9;
        en = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("reset_mid");
        @(posedge clk);
        #1;
        check_all("reset_low_edge");
        #2;
        reset = 1'b1;
        step(8'd9, 8'd9, 1'b0, "release_idle");
        step(8'd9, 8'd9, 1'b0, "release_idle2");

        // release with en already high
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        a  = 8'd12;
        b  = 8'd11;
        en = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset_en_hi");
        #2;
        reset = 1'b1;
        step(8'd12, 8'd11, 1'b1, "release_en_hi");

        // randomized traffic
        for (int i = 0; i < 300; i++)
            step(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
